// File: rtl/gfx_pkg.sv
// Shared types for the graphics command path: op encoding, command word, scheduler states
// and the on-screen clip rule used when clipping is compiled in.
package gfx_pkg;

  localparam logic GFX_OP_FILL = 1'b0;
  localparam logic GFX_OP_BLIT = 1'b1;

  localparam int GFX_SCREEN_W = 320;
  localparam int GFX_SCREEN_H = 200;

  typedef struct packed {
    logic       op;
    logic       fill_value;
    logic [8:0] x1;
    logic [7:0] y1;
    logic [8:0] x2;
    logic [7:0] y2;
    logic [8:0] width;
    logic [7:0] height;
  } gfx_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2
  } sched_state_t;

  // 10-bit sums cannot wrap: the largest coordinate plus the largest extent is 1022.
  function automatic logic gfx_clip_ok(input gfx_cmd_t c, input logic [9:0] sw,
                                       input logic [9:0] sh);
    logic [9:0] x1, x2, y1, y2, w, h;
    x1 = {1'b0, c.x1};
    x2 = {1'b0, c.x2};
    y1 = {2'b0, c.y1};
    y2 = {2'b0, c.y2};
    w  = {1'b0, c.width};
    h  = {2'b0, c.height};
    if (c.op == GFX_OP_FILL)
      return (x1 <= x2) && (x2 < sw) && (y1 <= y2) && (y2 < sh);
    return (w != '0) && (h != '0) && (x1 + w <= sw) && (x2 + w <= sw) &&
           (y1 + h <= sh) && (y2 + h <= sh);
  endfunction

endpackage

// File: rtl/gfx_cmd_fifo.sv
// Synchronous FIFO of gfx_cmd_t words; a push while full is accepted only when a pop
// retires the head in the same cycle.
module gfx_cmd_fifo
  import gfx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  gfx_cmd_t               i_wr_data,
  output gfx_cmd_t               o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  gfx_cmd_t         r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: storage has no reset; flushing the pointers and count empties the FIFO,
  // and every entry is written before it can be read.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= w_do_push ? i_wr_data : r_mem[r_wr_ptr];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gfx_cmd_sched.sv
// Command scheduler between the EPP registers and the blit/fill engine.
// Define GFX_SCHED_CLIP_EN to drop off-screen commands at push time and flag them on reject.
module gfx_cmd_sched
  import gfx_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int SCREEN_W = GFX_SCREEN_W,
  parameter int SCREEN_H = GFX_SCREEN_H
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  input  logic                   cmd_op,
  input  logic                   cmd_fill_value,
  input  logic [8:0]             cmd_x1,
  input  logic [8:0]             cmd_x2,
  input  logic [7:0]             cmd_y1,
  input  logic [7:0]             cmd_y2,
  input  logic [8:0]             cmd_width,
  input  logic [7:0]             cmd_height,
  output logic                   eng_start,
  output logic                   eng_op,
  output logic                   eng_fill_value,
  output logic [8:0]             eng_x1,
  output logic [7:0]             eng_y1,
  output logic [8:0]             eng_x2,
  output logic [7:0]             eng_y2,
  output logic [8:0]             eng_width,
  output logic [7:0]             eng_height,
  input  logic                   eng_done,
  input  logic                   clear_err,
  output logic                   sched_busy,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   overflow,
  output logic                   reject
);

  sched_state_t r_state, w_state_nxt;
  gfx_cmd_t     w_cmd, w_head, r_eng_cmd;
  logic         w_full, w_empty, w_pop, w_push;
  logic         w_clip_ok, w_cmd_ok, w_ovf_set;
  logic         r_overflow;

  assign w_cmd = '{op: cmd_op, fill_value: cmd_fill_value, x1: cmd_x1, y1: cmd_y1,
                   x2: cmd_x2, y2: cmd_y2, width: cmd_width, height: cmd_height};

  assign w_clip_ok = gfx_clip_ok(w_cmd, 10'(SCREEN_W), 10'(SCREEN_H));
`ifdef GFX_SCHED_CLIP_EN
  assign w_cmd_ok = w_clip_ok;
`else
  logic w_unused_clip;
  assign w_cmd_ok      = 1'b1;
  assign w_unused_clip = w_clip_ok;
`endif

  // A full queue still takes the push when the head leaves in the same cycle.
  assign w_push    = cmd_valid && w_cmd_ok && (!w_full || w_pop);
  assign w_ovf_set = cmd_valid && w_cmd_ok && w_full && !w_pop;

  gfx_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wr_data (w_cmd),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (queue_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    eng_start   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        eng_start   = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (eng_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands move only when a command is popped, so they stay put through RUN.
  always_ff @(posedge clk) begin
    if (!rst_n)     r_eng_cmd <= '0;
    else if (w_pop) r_eng_cmd <= w_head;
  end

  assign eng_op         = r_eng_cmd.op;
  assign eng_fill_value = r_eng_cmd.fill_value;
  assign eng_x1         = r_eng_cmd.x1;
  assign eng_y1         = r_eng_cmd.y1;
  assign eng_x2         = r_eng_cmd.x2;
  assign eng_y2         = r_eng_cmd.y2;
  assign eng_width      = r_eng_cmd.width;
  assign eng_height     = r_eng_cmd.height;

  assign sched_busy = (r_state != S_IDLE) || !w_empty;

  // Setting a flag takes priority over clearing it in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)         r_overflow <= 1'b0;
    else if (w_ovf_set) r_overflow <= 1'b1;
    else if (clear_err) r_overflow <= 1'b0;
  end
  assign overflow = r_overflow;

`ifdef GFX_SCHED_CLIP_EN
  logic r_reject;
  always_ff @(posedge clk) begin
    if (!rst_n)                      r_reject <= 1'b0;
    else if (cmd_valid && !w_cmd_ok) r_reject <= 1'b1;
    else if (clear_err)              r_reject <= 1'b0;
  end
  assign reject = r_reject;
`else
  assign reject = 1'b0;
`endif

endmodule

// File: doc/gfx_cmd_sched.md
# gfx_cmd_sched

Command scheduler between the EPP register block and the blit/fill engine. Captures each blit or fill request, with its full operand set, into a small FIFO so the host can post commands back-to-back without waiting. Dispatches queued commands one at a time to the engine, holding operands stable until the engine reports completion. Reports queue depth, busy state and sticky error flags back to the host-visible register space.

## Interface
Parameters:
- DEPTH, 4, command FIFO entries; power of two, 2..16
- SCREEN_W, 320, framebuffer width in pixels (clip check only)
- SCREEN_H, 200, framebuffer height in pixels (clip check only)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- cmd_valid  in  1  one-cycle request pulse (blit or fill start from EPP)
- cmd_op  in  1  0 = fill, 1 = blit
- cmd_fill_value  in  1  fill pixel value (ignored for blit)
- cmd_x1 / cmd_x2  in  9  source/first corner X, destination/second corner X
- cmd_y1 / cmd_y2  in  8  matching Y coordinates
- cmd_width  in  9  blit width
- cmd_height  in  8  blit height
- eng_start  out  1  one-cycle launch pulse to engine
- eng_op, eng_fill_value, eng_x1, eng_y1, eng_x2, eng_y2, eng_width, eng_height  out  1/1/9/8/9/8/9/8  registered operands to engine
- eng_done  in  1  one-cycle completion pulse from engine
- clear_err  in  1  clears sticky flags
- sched_busy  out  1  high when state is not IDLE or queue is non-empty
- queue_count  out  $clog2(DEPTH)+1  entries currently queued
- overflow  out  1  sticky: a command was dropped because the FIFO was full
- reject  out  1  sticky: a command failed the clip check (zero when clipping is compiled out)

## Operation
- Push: cmd_valid with queue not full writes the full command word (53 bits) at the tail. With queue full, the command is dropped and overflow is set. Exception: full plus a pop in the same cycle accepts the push.
- States: IDLE, LAUNCH, RUN.
  - IDLE: if queue_count > 0, pop the head, register it onto the eng_* outputs, go to LAUNCH.
  - LAUNCH: eng_start = 1 for exactly this cycle, go to RUN.
  - RUN: hold eng_* operands; on eng_done go to IDLE.
- eng_done outside RUN is ignored.
- Dispatch is strictly FIFO order. There is no reordering or merging.
- clear_err clears overflow and reject. If clear_err and a new error fall in the same cycle, the error wins and the flag stays set.
- Reset values:
  - eng_start, all eng_* operands, sched_busy, queue_count, overflow and reject are 0.
  - State is IDLE.
  - The FIFO is flushed, with read and write pointers at 0.
- Reset mid-operation abandons the in-flight command. The engine shares rst_n and is reset alongside.

## Timing
- cmd_valid high in cycle 0, with an empty queue and state IDLE: queue_count = 1 in cycle 1, eng_start high in cycle 2, queue_count = 0 in cycle 2.
- eng_done in cycle k: state IDLE in cycle k+1. The next queued command's eng_start is high in cycle k+2.
- Operands change only on the IDLE-to-LAUNCH transition, one cycle before eng_start. They are stable through the eng_done cycle.
- Pointers wrap modulo DEPTH. queue_count saturates at DEPTH.

## Configuration
- GFX_SCHED_CLIP_EN defined: each command is checked at push time, using 10-bit unsigned arithmetic, before it is written.
  - Fill passes if x1 <= x2 < SCREEN_W and y1 <= y2 < SCREEN_H.
  - Blit passes if width and height are nonzero, x1+width <= SCREEN_W, x2+width <= SCREEN_W, y1+height <= SCREEN_H and y2+height <= SCREEN_H.
  - Failing commands are dropped and set reject. They are never queued.
- Not defined: no check, every command within capacity is queued, and reject is tied to 0.

## Structure
- Shared package gfx_pkg holds:
  - the op encoding constants (GFX_OP_FILL = 0, GFX_OP_BLIT = 1)
  - the packed command struct gfx_cmd_t (op, fill_value, x1, y1, x2, y2, width, height)
  - the scheduler state enum
  - default SCREEN_W and SCREEN_H
- Sub-module gfx_cmd_fifo: parameterised synchronous FIFO of gfx_cmd_t, DEPTH entries, with push, pop, full, empty and count. The scheduler FSM, clip check and flags live in gfx_cmd_sched.

## Test plan
- Single fill: cmd_valid cycle 0 with op=0, x1=20, y1=40, x2=90, y2=100, value=1 -> eng_start in cycle 2 only, with exactly those operands; sched_busy drops the cycle after eng_done.
- Back-to-back: 3 blits pushed on consecutive cycles, engine done 10 cycles after each start -> three eng_start pulses in push order, each 2 cycles after the previous eng_done; operands held during RUN.
- Overflow: DEPTH=4, engine stalled, 6 pushes -> 4 entries queued (one already in RUN), remaining pushes dropped, overflow=1; clear_err -> overflow=0.
- Full plus pop: queue full, push in the same cycle as the IDLE pop -> push accepted, queue_count stays DEPTH.
- Clip (with GFX_SCHED_CLIP_EN): blit x1=300, width=30 -> dropped, reject=1, no eng_start; blit x1=290, width=30 -> accepted.
- Reset mid-RUN: rst_n low for 1 cycle with 2 entries queued -> queue_count=0, state IDLE, eng_start stays 0 and flags=0; a later stray eng_done is ignored.
